// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Run/step/halt controller for the MIPS core. The core no longer gets its own
// divided clock. It runs on clk and advances one instruction on each cycle that
// cpu_en is high. This block decides when those cycles happen. It supports a
// programmable divide rate, single-step, halt and a PC breakpoint, all for
// board-level debug.
//
// Parameters
//   WIDTH        width of the divide register and the tick counter
//   DEFAULT_DIV  divide value loaded at reset (cpu_en period in clk cycles)
//   PC_W         width of pc_in / bp_addr
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   run_req      1-cycle pulse: enter RUN
//   halt_req     1-cycle pulse: enter HALT (highest priority)
//   step_req     1-cycle pulse: issue exactly one cpu_en
//   div_load     load div_value into the divide register (any state)
//   div_value    new divide value (0 is stored as 1)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc_in        current core PC
//   cpu_en       one-clk-wide advance pulse to the core
//   state        HALT=00, RUN=01, STEP=10, BREAK=11
//   retired_cnt  (only with CPU_CLK_CTRL_PERF_EN) count of cpu_en pulses;
//                wraps at 2^32 and is cleared by reset and by div_load
//
// Build option
//   CPU_CLK_CTRL_PERF_EN  when defined, adds the retired_cnt port and counter.
//
// Timing notes
//   - In RUN, cpu_en is a combinational decode of the registered counter. It is
//     gated by the same-cycle requests, so halt_req, step_req or div_load in a
//     due cycle still suppresses that pulse. With run_req seen in cycle 0, the
//     pulses fall in cycles DIV, 2*DIV, ...
//   - In STEP, cpu_en is a pure decode of the state register. It is therefore
//     high in the cycle after step_req.
//   - On asynchronous reset, cpu_en drops at once because the state register
//     returns to HALT.
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 50000000,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             cpu_en,
  output logic [1:0]       state
`ifdef CPU_CLK_CTRL_PERF_EN
  ,
  output logic [31:0]      retired_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  // A divide of 0 has no meaning, so it is treated as 1, both here and on load.
  localparam logic [WIDTH-1:0] DIV_RESET =
    (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg,   cnt_next;
  logic [WIDTH-1:0] div_reg,   div_next;
  logic             skip_bp_reg, skip_bp_next;

  logic             tick_due;
  logic             bp_hit;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_HALT;
      cnt_reg     <= '0;
      div_reg     <= DIV_RESET;
      skip_bp_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      skip_bp_reg <= skip_bp_next;
    end
  end

  // div_reg is always >= 1, so this subtraction cannot wrap. The cnt clear on
  // every load keeps cnt at or below div_reg-1, even when the new divide value
  // is smaller than the current count.
  assign tick_due = (cnt_reg == (div_reg - WIDTH'(1)));

  // skip_bp lets the first due pulse after resuming from BREAK issue even
  // though pc_in still equals bp_addr. Without it the core could never move
  // off the breakpoint.
  assign bp_hit = bp_en && (pc_in == bp_addr) && !skip_bp_reg;

  // The load is independent of state. The new value first governs the count
  // that starts in the next cycle.
  always_comb begin
    div_next = div_reg;
    if (div_load) begin
      div_next = (div_value == '0) ? WIDTH'(1) : div_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output decode
  // Request priority is halt_req > step_req > run_req. Lower-priority requests
  // in the same cycle are dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    skip_bp_next = skip_bp_reg;
    cpu_en       = 1'b0;

    unique case (state_reg)
      ST_HALT: begin
        cnt_next = '0;
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (step_req) begin
          state_next = ST_STEP;
        end else if (run_req) begin
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (halt_req) begin
          state_next = ST_HALT;
          cnt_next   = '0;
        end else if (step_req) begin
          state_next = ST_STEP;
          cnt_next   = '0;
        end else if (div_load) begin
          // The load restarts the count. Any tick due this cycle is abandoned.
          cnt_next = '0;
        end else if (tick_due) begin
          cnt_next = '0;
          if (bp_hit) begin
            state_next = ST_BREAK;
          end else begin
            cpu_en       = 1'b1;
            skip_bp_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end

      ST_STEP: begin
        // The single-step pulse always issues, without a breakpoint check.
        // Every request is ignored for this one cycle. The state always falls
        // back to HALT, so cpu_en cannot be high in two consecutive cycles.
        cpu_en     = 1'b1;
        cnt_next   = '0;
        state_next = ST_HALT;
      end

      ST_BREAK: begin
        cnt_next = '0;
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (step_req) begin
          state_next = ST_STEP;
        end else if (run_req) begin
          state_next   = ST_RUN;
          skip_bp_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_HALT;
        cnt_next   = '0;
      end
    endcase

    if (div_load) begin
      cnt_next = '0;
    end
  end

  assign state = state_reg;

`ifdef CPU_CLK_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Retired-instruction counter. div_load clears it, which gives each new rate
  // setting a fresh measurement window. The clear wins over a same-cycle pulse.
  // ---------------------------------------------------------------------------
  logic [31:0] retired_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_reg <= '0;
    end else if (div_load) begin
      retired_reg <= '0;
    end else if (cpu_en) begin
      retired_reg <= retired_reg + 32'd1;
    end
  end

  assign retired_cnt = retired_reg;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
//
// Self-checking bench for cpu_clk_ctrl, built with DEFAULT_DIV = 4.
//
// The reference model schedules pulses in absolute time. When RUN is entered,
// or the divide value is reloaded, at cycle n, the next pulse is due at
// n + div. After a pulse at cycle p, the next one is due at p + div. The model
// predicts cpu_en and state for every cycle. It also predicts retired_cnt when
// CPU_CLK_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

  localparam int W    = 32;
  localparam int PW   = 32;
  localparam int DDIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run_req, halt_req, step_req, div_load;
  logic [W-1:0]  div_value;
  logic          bp_en;
  logic [PW-1:0] bp_addr, pc_in;
  logic          cpu_en;
  logic [1:0]    state;
`ifdef CPU_CLK_CTRL_PERF_EN
  logic [31:0]   retired_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  int          n;        // cycle number
  int          m_mode;   // 0 halt, 1 run, 2 step, 3 break
  int          m_due;    // absolute cycle of next due pulse in RUN
  int          m_div;
  bit          m_skip;
  logic [31:0] m_retired;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.WIDTH(W), .DEFAULT_DIV(DDIV), .PC_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .div_load  (div_load),
    .div_value (div_value),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc_in     (pc_in),
    .cpu_en    (cpu_en),
    .state     (state)
`ifdef CPU_CLK_CTRL_PERF_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  task automatic model_reset();
    m_mode    = 0;
    m_due     = 0;
    m_div     = DDIV;
    m_skip    = 0;
    m_retired = 0;
  endtask

  function automatic bit exp_en();
    bit hit;
    hit = bp_en && (pc_in == bp_addr) && !m_skip;
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1 && !halt_req && !step_req && !div_load && n == m_due && !hit)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, n, got, want);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, want);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, step the model.
  task automatic cyc(input bit r, input bit h, input bit s, input bit ld, input int dv);
    bit en_e, hit;
    int nd;
    run_req   = r;
    halt_req  = h;
    step_req  = s;
    div_load  = ld;
    div_value = W'(dv);
    @(negedge clk);
    en_e = exp_en();
    check_bit("cpu_en", cpu_en, en_e);
    check_vec("state", {30'd0, state}, m_mode);
`ifdef CPU_CLK_CTRL_PERF_EN
    check_vec("retired", retired_cnt, m_retired);
`endif
    $display("cyc=%0d r=%0b h=%0b s=%0b ld=%0b dv=%0d pc=%0h cpu_en=%0b state=%0d", n, r, h, s, ld, dv, pc_in, cpu_en, state);
    hit = bp_en && (pc_in == bp_addr) && !m_skip;
    nd  = ld ? ((dv == 0) ? 1 : dv) : m_div;
    case (m_mode)
      0: if (h) m_mode = 0;
         else if (s) m_mode = 2;
         else if (r) begin m_mode = 1; m_due = n + nd; end
      1: if (h) m_mode = 0;
         else if (s) m_mode = 2;
         else if (ld) m_due = n + nd;
         else if (n == m_due) begin
           if (hit) m_mode = 3;
           else begin m_skip = 0; m_due = n + m_div; end
         end
      2: m_mode = 0;
      default: if (h) m_mode = 0;
         else if (s) m_mode = 2;
         else if (r) begin m_mode = 1; m_skip = 1; m_due = n + nd; end
    endcase
    if (ld) m_retired = 0;
    else if (en_e) m_retired = m_retired + 1;
    m_div = nd;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    run_req = 0; halt_req = 0; step_req = 0; div_load = 0; div_value = '0;
    bp_en = 0; bp_addr = 32'h20; pc_in = '0;
    n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_bit("rst_cpu_en", cpu_en, 1'b0);
    check_vec("rst_state", {30'd0, state}, 32'd0);
`ifdef CPU_CLK_CTRL_PERF_EN
    check_vec("rst_retired", retired_cnt, 32'd0);
`endif
    reset = 1'b0;

    // RUN at default divide 4: pulses at cycles 4, 8, 12 after run_req
    cyc(1, 0, 0, 0, 0);
    idle(13);
    cyc(0, 1, 0, 0, 0);
    idle(2);

    // single steps
    cyc(0, 0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0, 0);
    idle(3);

    // breakpoint at 0x20, divide 3
    bp_en = 1; pc_in = 32'h20;
    cyc(0, 0, 0, 1, 3);
    cyc(1, 0, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0, 0);   // resume from BREAK: skip one match
    idle(8);

    // halt and step together while in RUN
    bp_en = 0;
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 1, 0, 0);
    idle(2);

    // divide 0 -> 1: continuous enable
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0, 0);
    idle(1);

    // randomized stretch
    for (int i = 0; i < 400; i++) begin
      bp_en = ($urandom_range(0, 3) == 0);
      pc_in = ($urandom_range(0, 1) == 0) ? 32'h20 : 32'h24;
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 5));
    end
    bp_en = 0;
    cyc(0, 1, 0, 0, 0);

`ifdef CPU_CLK_CTRL_PERF_EN
    // five steps then a load
    cyc(0, 0, 0, 1, 4);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0);
      idle(2);
    end
    check_vec("retired_5", retired_cnt, 32'd5);
    cyc(0, 0, 0, 1, 4);
    check_vec("retired_clr", retired_cnt, 32'd0);
`endif

    // asynchronous reset in the middle of a pulse
    cyc(0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 0);
    found = 0;
    run_req = 0; halt_req = 0; step_req = 0; div_load = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_en()) found = 1;
      else idle(1);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_pulse cyc=%0d got=none exp=pulse", n);
    end
    #3;
    check_bit("pre_rst_en", cpu_en, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("async_rst_en", cpu_en, 1'b0);
    check_vec("async_rst_state", {30'd0, state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n++;
    model_reset();
    // divide restored to DEFAULT_DIV: pulse 4 cycles after run_req
    cyc(1, 0, 0, 0, 0);
    idle(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Run/step/halt controller for the MIPS core's clocking.
- Replaces free-running divided clocks with a single-cycle clock-enable pulse (cpu_en) generated in the clk domain. The core advances one instruction per pulse.
- Provides a programmable divide rate, single-step, halt and a PC breakpoint for board-level debug.
- Sits between board buttons/switches (pre-debounced) and the core's register/PC enables.

Parameters:
- WIDTH, 32, width of divide register and tick counter.
- DEFAULT_DIV, 50000000, divide value loaded at reset (cpu_en period in clk cycles).
- PC_W, 32, width of pc_in and bp_addr.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- run_req  input  1  one-cycle pulse: enter RUN.
- halt_req  input  1  one-cycle pulse: enter HALT.
- step_req  input  1  one-cycle pulse: issue exactly one cpu_en.
- div_load  input  1  load div_value into divide register.
- div_value  input  WIDTH  new divide value.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PC_W  breakpoint PC.
- pc_in  input  PC_W  current core PC.
- cpu_en  output  1  one-clk-wide advance pulse to core.
- state  output  2  HALT=00, RUN=01, STEP=10, BREAK=11.

Behaviour:
- Reset values: state=HALT, cpu_en=0, cnt=0, div_reg=DEFAULT_DIV, skip_bp=0.
- div_reg rules:
  - div_load: div_reg<=div_value and cnt<=0 in the same cycle, in any state.
  - div_value==0 is stored as 1.
  - div_load takes effect for the next tick; no pulse is issued in the load cycle.
- Request priority in the same cycle: halt_req > step_req > run_req. Lower-priority requests that cycle are dropped.
- HALT:
  - cnt held at 0; cpu_en=0.
  - run_req -> RUN. step_req -> STEP.
- RUN:
  - cnt increments each clk.
  - When cnt==div_reg-1: cnt<=0, and a pulse is due.
  - Due pulse with bp_en && pc_in==bp_addr && !skip_bp: pulse suppressed, state<=BREAK.
  - Otherwise cpu_en=1 for exactly one cycle and skip_bp<=0.
  - First pulse after entering RUN occurs div_reg cycles after entry (cnt starts at 0).
  - halt_req -> HALT (cnt<=0, no pulse that cycle even if due).
  - step_req in RUN -> STEP (cnt<=0).
- STEP:
  - Entered from HALT/BREAK/RUN.
  - cpu_en=1 on the first cycle in STEP (registered: one cycle after step_req).
  - Next cycle state<=HALT.
  - Breakpoint is not checked in STEP.
  - halt_req during the STEP cycle still lets the pulse issue, then goes to HALT.
- BREAK:
  - cpu_en=0; cnt held at 0.
  - run_req -> RUN with skip_bp<=1, so the first due pulse ignores the breakpoint and the core can leave bp_addr.
  - step_req -> STEP. halt_req -> HALT.
- cpu_en is never high two consecutive cycles, except in RUN with div_reg==1 (continuous enable).
- cnt compare is unsigned, full WIDTH. cnt never exceeds div_reg-1. A div_load lowering div_reg below cnt is safe because cnt is cleared on load.
- Asynchronous reset mid-pulse: cpu_en drops immediately; all state as per reset values.

Optional Feature:
- Macro: CPU_CLK_CTRL_PERF_EN.
- Defined:
  - Adds output port retired_cnt [31:0], incremented on every cpu_en pulse.
  - Wraps 0xFFFFFFFF->0. Reset to 0.
  - Additionally cleared by div_load.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, DEFAULT_DIV overridden to 4, run_req at cycle 0 -> cpu_en high on cycles 4, 8, 12 after entry; state=01.
- From HALT, step_req pulse -> exactly one cpu_en, one cycle later; state 00->10->00. Two steps 3 cycles apart -> two pulses.
- div=3, bp_en=1, bp_addr=0x20, pc_in=0x20 in RUN -> no cpu_en, state=11. run_req -> next due pulse issues with pc_in still 0x20; later match breaks again.
- halt_req and step_req asserted in the same cycle while in RUN -> state=00, no cpu_en. div_load with div_value=0 then run_req -> cpu_en high every cycle.
- Async reset asserted mid-RUN with cpu_en=1 -> cpu_en=0 immediately, state=00, div restored to DEFAULT_DIV.
- With CPU_CLK_CTRL_PERF_EN: 5 steps -> retired_cnt=5; div_load -> retired_cnt=0.
